// File: rtl/ysyx_22040237_idu_pkg.sv
// Shared constants and decoded-entry layout for the decode/issue stage.
package ysyx_22040237_idu_pkg;

  localparam int IDU_XLEN = 64;

  localparam logic [7:0] INST_NOP = 8'h00;
  localparam logic [7:0] INST_ADD = 8'h01;

  localparam logic [6:0] RV_OP     = 7'b0110011;
  localparam logic [6:0] RV_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV_LUI    = 7'b0110111;
  localparam logic [6:0] RV_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV_SYSTEM = 7'b1110011;

  localparam logic [31:0] RV_EBREAK = 32'h00100073;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } idu_state_t;

  typedef struct packed {
    logic [IDU_XLEN-1:0] pc;
    logic [IDU_XLEN-1:0] op1;
    logic [IDU_XLEN-1:0] op2;
    logic [7:0]          opcode;
    logic [4:0]          rd;
    logic                rd_wen;
    logic                ebreak;
  } idu_entry_t;

endpackage

// File: rtl/ysyx_22040237_idu_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers reset, storage does not.
module ysyx_22040237_idu_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rd_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);

endmodule

// File: rtl/ysyx_22040237_idu.sv
// Decode/issue stage: RV64I ADD/ADDI/LUI/AUIPC/EBREAK into a small issue FIFO with a busy scoreboard.
// Define YSYX_22040237_WB_BYPASS_EN to forward the writeback port straight into operand read.
module ysyx_22040237_idu
  import ysyx_22040237_idu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic [4:0]      rf_rs1_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [7:0]      inst_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rd_wen,
  output logic            inst_ebreak,
  output logic [XLEN-1:0] ex_pc,
  output logic            halted
);

  localparam int ENTRY_W = $bits(idu_entry_t);

  logic [6:0]  rv_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_add, is_addi, is_lui, is_auipc, is_ebreak;
  logic        byp1, byp2, hazard, fire_in;
  logic signed [XLEN-1:0] imm_i_p0;
  logic signed [XLEN-1:0] imm_u_p0;
  logic [XLEN-1:0] rs1_val_p0;
  logic [XLEN-1:0] rs2_val_p0;
  logic [31:0]     busy, busy_nxt;
  idu_state_t      state, state_nxt;
  idu_entry_t      dec_p0, head_p1;
  logic            vld_p1;
  logic [ENTRY_W-1:0]          fifo_rd;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full, fifo_empty;

  assign rv_op  = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];
  assign funct7 = if_inst[31:25];

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  assign is_add    = (rv_op == RV_OP) & (funct3 == 3'b000) & (funct7 == 7'b0000000);
  assign is_addi   = (rv_op == RV_OP_IMM) & (funct3 == 3'b000);
  assign is_lui    = (rv_op == RV_LUI);
  assign is_auipc  = (rv_op == RV_AUIPC);
  assign is_ebreak = (rv_op == RV_SYSTEM) & (if_inst[31:7] == RV_EBREAK[31:7]);

  assign imm_i_p0 = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign imm_u_p0 = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'h000};

`ifdef YSYX_22040237_WB_BYPASS_EN
  assign byp1 = wb_en & (wb_addr == rs1);
  assign byp2 = wb_en & (wb_addr == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rs1_val_p0 = (rs1 == 5'd0) ? '0 : (byp1 ? wb_data : rf_rs1_data);
  assign rs2_val_p0 = (rs2 == 5'd0) ? '0 : (byp2 ? wb_data : rf_rs2_data);

  // Only ADD/ADDI actually consume register sources, so only they can stall.
  assign hazard = ((is_add | is_addi) & (rs1 != 5'd0) & busy[rs1] & ~byp1) |
                  (is_add & (rs2 != 5'd0) & busy[rs2] & ~byp2);

  assign if_ready = rst & (state == ST_RUN) & ~fifo_full & ~hazard;
  assign fire_in  = if_valid & if_ready;

  always_comb begin
    dec_p0        = '0;
    dec_p0.pc     = if_pc;
    dec_p0.rd     = rd;
    dec_p0.opcode = INST_NOP;
    if (is_add) begin
      dec_p0.opcode = INST_ADD;
      dec_p0.op1    = rs1_val_p0;
      dec_p0.op2    = rs2_val_p0;
      dec_p0.rd_wen = 1'b1;
    end else if (is_addi) begin
      dec_p0.opcode = INST_ADD;
      dec_p0.op1    = rs1_val_p0;
      dec_p0.op2    = imm_i_p0;
      dec_p0.rd_wen = 1'b1;
    end else if (is_lui) begin
      dec_p0.opcode = INST_ADD;
      dec_p0.op2    = imm_u_p0;
      dec_p0.rd_wen = 1'b1;
    end else if (is_auipc) begin
      dec_p0.opcode = INST_ADD;
      dec_p0.op1    = if_pc;
      dec_p0.op2    = imm_u_p0;
      dec_p0.rd_wen = 1'b1;
    end else if (is_ebreak) begin
      dec_p0.ebreak = 1'b1;
    end
    if (rd == 5'd0) dec_p0.rd_wen = 1'b0;
  end

  // Clear first so that a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_addr] = 1'b0;
    if (fire_in & dec_p0.rd_wen) busy_nxt[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_RUN) & fire_in & dec_p0.ebreak) state_nxt = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  assign halted = (state == ST_HALT);

  // ---- p0 -> p1: decoded entry enters the issue FIFO ----
  ysyx_22040237_idu_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fire_in),
    .wr_data(dec_p0),
    .pop    (ex_valid & ex_ready),
    .rd_data(fifo_rd),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Storage is not reset, so an empty FIFO presents an all-zero head.
  assign vld_p1  = ~fifo_empty;
  assign head_p1 = (fifo_count != '0) ? idu_entry_t'(fifo_rd) : '0;

  assign ex_valid    = vld_p1;
  assign inst_opcode = head_p1.opcode;
  assign op1         = head_p1.op1;
  assign op2         = head_p1.op2;
  assign ex_rd_addr  = head_p1.rd;
  assign ex_rd_wen   = head_p1.rd_wen;
  assign inst_ebreak = head_p1.ebreak;
  assign ex_pc       = head_p1.pc;

endmodule

// File: doc/ysyx_22040237_idu.md
Name: ysyx_22040237_idu

Overview:
Decode/issue stage feeding the execute unit. It accepts instructions from the fetch side over a valid/ready handshake and decodes RV64I ADD, ADDI, LUI, AUIPC and EBREAK into the execute unit's operand interface (opcode, op1, op2, ebreak flag). It reads the external register file, tracks pending writes with a scoreboard, and buffers decoded entries in a 2-entry FIFO toward execute. On EBREAK it enters a halted state.

Parameters:
FIFO_DEPTH, 2, decoded-entry buffer depth (power of two, ≥2)
XLEN, 64, datapath width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_valid  in  1  fetch offers instruction
if_ready  out  1  stage accepts instruction this cycle
if_pc  in  64  PC of offered instruction
if_inst  in  32  instruction word
rf_rs1_addr  out  5  regfile read addr 1 = if_inst[19:15]
rf_rs1_data  in  64  combinational read data 1
rf_rs2_addr  out  5  regfile read addr 2 = if_inst[24:20]
rf_rs2_data  in  64  combinational read data 2
wb_en  in  1  writeback strobe
wb_addr  in  5  writeback register
wb_data  in  64  writeback value
ex_valid  out  1  FIFO head valid toward execute
ex_ready  in  1  execute consumes head
inst_opcode  out  8  internal opcode of head
op1  out  64  operand 1 of head
op2  out  64  operand 2 of head
ex_rd_addr  out  5  destination of head
ex_rd_wen  out  1  head writes rd
inst_ebreak  out  1  head is EBREAK
ex_pc  out  64  PC of head
halted  out  1  EBREAK accepted; no further issue

Behaviour:
- Reset (rst=0, async): FIFO empty, scoreboard all 0, state RUN. Outputs ex_valid=0, halted=0, if_ready=0, all head fields 0.
- Accept: fire_in = if_valid & if_ready. Decode and operand read happen in the accept cycle; the entry is written into the FIFO tail. Earliest ex_valid is the next cycle (latency 1).
- if_ready = rst & state==RUN & FIFO not full & no hazard.
- Decode (all arithmetic maps to INST_ADD; EXU computes op1+op2):
  - ADD: op1=rs1, op2=rs2, wen=1.
  - ADDI: op1=rs1, op2=sext(imm12), wen=1.
  - LUI: op1=0, op2=sext({imm20,12'b0}), wen=1.
  - AUIPC: op1=if_pc, op2=sext({imm20,12'b0}), wen=1.
  - EBREAK (0x00100073): opcode INST_NOP, inst_ebreak=1, wen=0.
  - Any other word: opcode INST_NOP, wen=0.
  - rd=x0 forces wen=0. Register x0 reads as 0 regardless of rf data.
- Scoreboard: 32 busy bits. Set bit rd on accept when wen=1. Clear bit wb_addr on wb_en. Same-cycle set and clear of the same register: set wins.
- Hazard: a used source (rs1 for ADD/ADDI; rs2 for ADD) that is nonzero and busy. Exception: wb_en clears that register this cycle and bypass applies (see Optional Feature).
- FIFO output: head fields drive ex_* directly. Pop on ex_valid & ex_ready. Simultaneous push and pop when full is not allowed, because if_ready is 0 when full. Push and pop at count=1 keep count=1. Order is strictly preserved; pointers wrap modulo FIFO_DEPTH.
- State RUN→HALT on accepting EBREAK. halted=1 from the next cycle; HALT is left only by reset. Entries already buffered still drain to execute.
- Reset mid-operation: FIFO contents and scoreboard are discarded immediately.

Optional Feature:
Macro YSYX_22040237_WB_BYPASS_EN.
- Defined: a source matching wb_addr with wb_en=1 is not a hazard, and the operand takes wb_data in that cycle.
- Undefined: a busy source stalls until the cycle after its busy bit clears, and the operand then comes from rf_rs*_data.

Decomposition:
- Shared package/defines: INST_NOP=8'h00, INST_ADD=8'h01, RV opcode constants (OP, OP_IMM, LUI, AUIPC, SYSTEM), EBREAK encoding, decoded-entry field layout.
- One sub-module: ysyx_22040237_idu_fifo, a generic FIFO_DEPTH-entry synchronous FIFO with count, full and empty.

Test Plan:
- Assert rst=0 mid-stream with 2 entries buffered → ex_valid=0 and halted=0 immediately. After release, if_ready=1 and the old entries never appear.
- Issue ADDI x3,x0,-1 (0xFFF00193) → opcode 0x01, op1=0, op2=0xFFFFFFFFFFFFFFFF, rd=3, wen=1, one cycle after accept.
- Issue LUI x5,0x12345 (0x123452B7), then AUIPC x10,1 (0x00001517) at pc 0x80000000 → first entry op2=0x12345000, op1=0; second entry op1=0x80000000, op2=0x1000.
- Issue ADDI x1,x0,5 (0x00500093), then ADD x2,x1,x1 (0x00108133) → if_ready=0 until wb_en addr=1 data=5. With bypass, accept happens in the wb cycle with op1=op2=5. Without bypass, accept happens one cycle later.
- Hold ex_ready=0 for 3 cycles while issuing 3 independent ADDIs → 2 buffered, if_ready=0 on the third. Release ex_ready → all 3 emerge in order.
- Issue EBREAK (0x00100073) → head has inst_ebreak=1, wen=0. halted=1 the next cycle and if_ready stays 0 with if_valid=1.
